// File: rtl/irq_ctrl.sv
// irq_ctrl: six-source priority interrupt controller with MASK/PEND/STAT/CTRL registers.
// Define IRQ_LEVEL_EN for level-sensitive pending bits; the default build is edge-triggered.
`timescale 1ns/1ps
module irq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  DevIrq,
    input  logic        WE,
    input  logic [1:0]  Addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IntReq,
    output logic [2:0]  IntId,
    input  logic        IntAck,
    input  logic        Eoi
);
    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t      stateQ, stateD;
    logic [5:0]  devIrqQ;
    logic [5:0]  pendQ, pendD;
    logic [5:0]  maskQ, maskD;
    logic        genQ, genD;
    logic        intReqQ, intReqD;
    logic [2:0]  intIdQ, intIdD;
    logic [5:0]  active;
    logic        anyActive;
    logic [2:0]  selId;
    logic        unusedWd;

    assign unusedWd  = ^WD[31:6];
    assign active    = pendQ & maskQ;
    assign anyActive = |active;

    // Lowest pending-and-enabled index wins; device 0 has highest priority.
    always_comb begin
        selId = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (active[i]) selId = 3'(i);
        end
    end

    always_comb begin
        stateD  = stateQ;
        intIdD  = intIdQ;
        intReqD = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (genQ && anyActive) begin
                    stateD  = REQ;
                    intIdD  = selId;
                    intReqD = 1'b1;
                end
            end
            REQ: begin
                if (!genQ || !anyActive) begin
                    stateD = IDLE;
                end else if (IntAck) begin
                    stateD = SVC;
                end else begin
                    intIdD  = selId;
                    intReqD = 1'b1;
                end
            end
            SVC: begin
                if (Eoi) stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        maskD = maskQ;
        genD  = genQ;
        if (WE && Addr == 2'd0) maskD = WD[5:0];
        if (WE && Addr == 2'd3) genD  = WD[0];
    end

`ifdef IRQ_LEVEL_EN
    always_comb begin
        pendD = DevIrq;
    end
`else
    logic [5:0] w1cClr;
    logic [5:0] ackClr;

    // A rising edge in the same cycle as a clear (W1C or acknowledge) wins, so the bit stays set.
    always_comb begin
        w1cClr = (WE && Addr == 2'd1) ? WD[5:0] : 6'd0;
        ackClr = 6'd0;
        if (stateQ == REQ && genQ && anyActive && IntAck) ackClr[intIdQ] = 1'b1;
        pendD = (pendQ & ~(w1cClr | ackClr)) | (DevIrq & ~devIrqQ);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ  <= IDLE;
            devIrqQ <= 6'd0;
            pendQ   <= 6'd0;
            maskQ   <= 6'd0;
            genQ    <= 1'b0;
            intReqQ <= 1'b0;
            intIdQ  <= 3'd0;
        end else begin
            stateQ  <= stateD;
            devIrqQ <= DevIrq;
            pendQ   <= pendD;
            maskQ   <= maskD;
            genQ    <= genD;
            intReqQ <= intReqD;
            intIdQ  <= intIdD;
        end
    end

    always_comb begin
        RD = 32'd0;
        case (Addr)
            2'd0:    RD[5:0] = maskQ;
            2'd1:    RD[5:0] = pendQ;
            2'd2:    RD[3:0] = {stateQ == SVC, intIdQ};
            2'd3:    RD[0]   = genQ;
            default: RD      = 32'd0;
        endcase
    end

    assign IntReq = intReqQ;
    assign IntId  = intIdQ;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_irq_ctrl;
    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SVC  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  DevIrq;
    logic        WE;
    logic [1:0]  Addr;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IntReq;
    logic [2:0]  IntId;
    logic        IntAck;
    logic        Eoi;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Behavioural model state
    bit [5:0] mPend = '0;
    bit [5:0] mMask = '0;
    bit [5:0] mPrev = '0;
    bit       mGen  = 1'b0;
    int       mMode = M_IDLE;
    int       mId   = 0;

    irq_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .DevIrq (DevIrq),
        .WE     (WE),
        .Addr   (Addr),
        .WD     (WD),
        .RD     (RD),
        .IntReq (IntReq),
        .IntId  (IntId),
        .IntAck (IntAck),
        .Eoi    (Eoi)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRd(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: r[5:0] = mMask;
            2'd1: r[5:0] = mPend;
            2'd2: r = ((mMode == M_SVC) ? 32'd8 : 32'd0) + (mId % 8);
            2'd3: r[0] = mGen;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Reference model: rules applied at each rising edge from the pre-edge inputs.
    always @(posedge clk or posedge reset) begin : refModel
        int       sel;
        bit       ackNow;
        bit [5:0] nPend;
        if (reset) begin
            mPend = '0; mMask = '0; mPrev = '0; mGen = 1'b0; mMode = M_IDLE; mId = 0;
        end else begin
            sel = -1;
            for (int i = 5; i >= 0; i--) if (mPend[i] && mMask[i]) sel = i;
            ackNow = (mMode == M_REQ) && mGen && (sel >= 0) && IntAck;
            for (int i = 0; i < 6; i++) begin
`ifdef IRQ_LEVEL_EN
                nPend[i] = DevIrq[i];
`else
                nPend[i] = (DevIrq[i] && !mPrev[i]) ||
                           (mPend[i] && !(WE && Addr == 2'd1 && WD[i]) && !(ackNow && mId == i));
`endif
            end
            case (mMode)
                M_IDLE: if (mGen && sel >= 0) begin mMode = M_REQ; mId = sel; end
                M_REQ: begin
                    if (!mGen || sel < 0) mMode = M_IDLE;
                    else if (IntAck)      mMode = M_SVC;
                    else                  mId = sel;
                end
                M_SVC: if (Eoi) mMode = M_IDLE;
                default: mMode = M_IDLE;
            endcase
            mPend = nPend;
            mPrev = DevIrq;
            if (WE && Addr == 2'd0) mMask = WD[5:0];
            if (WE && Addr == 2'd3) mGen  = WD[0];
        end
    end

    // Compare DUT against the model mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_IntReq", {31'd0, IntReq}, (mMode == M_REQ) ? 32'd1 : 32'd0);
            checkOutput("cyc_IntId", {29'd0, IntId}, mId);
            checkOutput("cyc_RD", RD, modelRd(Addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        WE = 1'b1; Addr = a; WD = d;
        tick();
        WE = 1'b0; WD = 32'd0;
    endtask

    task automatic readCheck(input string name, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        checkOutput(name, RD, exp);
    endtask

    task automatic waitReq(input int maxCycles);
        int n = 0;
        while (!IntReq && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("waitReq", {31'd0, IntReq}, 32'd1);
    endtask

    task automatic applyStimulus();
        if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        for (int i = 0; i < 6; i++) if ($urandom_range(0, 7) == 0) DevIrq[i] = ~DevIrq[i];
        IntAck = ($urandom_range(0, 2) == 0);
        Eoi    = ($urandom_range(0, 3) == 0);
        Addr   = 2'($urandom_range(0, 3));
        WE     = ($urandom_range(0, 9) == 0);
        WD     = $urandom | $urandom;
        if (Addr == 2'd3) WD[0] = ($urandom_range(0, 3) != 0);
        tick();
        WE = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; DevIrq = 6'd0; WE = 1'b0; Addr = 2'd0; WD = 32'd0; IntAck = 1'b0; Eoi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkEn = 1'b1;

        readCheck("rst_MASK", 2'd0, 32'h0);
        readCheck("rst_PEND", 2'd1, 32'h0);
        readCheck("rst_STAT", 2'd2, 32'h0);
        readCheck("rst_CTRL", 2'd3, 32'h0);
        checkOutput("rst_IntReq", {31'd0, IntReq}, 32'd0);

`ifdef IRQ_LEVEL_EN
        writeReg(2'd0, 32'h20);
        writeReg(2'd3, 32'h1);
        DevIrq = 6'h20;
        for (int k = 0; k < 3; k++) begin
            waitReq(10);
            checkOutput("lvl_IntId", {29'd0, IntId}, 32'd5);
            if (k == 2) DevIrq = 6'h00;
            IntAck = 1'b1; tick(); IntAck = 1'b0;
            if (k < 2) readCheck("lvl_PEND", 2'd1, 32'h20);
            Eoi = 1'b1; tick(); Eoi = 1'b0;
        end
        tick(); tick();
        checkOutput("lvl_quiet", {31'd0, IntReq}, 32'd0);
`else
        // Single source: pend on the edge, request one edge later.
        writeReg(2'd0, 32'h3F);
        writeReg(2'd3, 32'h1);
        DevIrq = 6'h04;
        tick();
        readCheck("e1_PEND", 2'd1, 32'h04);
        checkOutput("e1_noReqYet", {31'd0, IntReq}, 32'd0);
        tick();
        checkOutput("e1_IntReq", {31'd0, IntReq}, 32'd1);
        checkOutput("e1_IntId", {29'd0, IntId}, 32'd2);
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        readCheck("e1_PENDack", 2'd1, 32'h00);
        Eoi = 1'b1; tick(); Eoi = 1'b0;
        DevIrq = 6'h00; tick();

        // Two simultaneous sources: priority, acknowledge, then the lower one.
        DevIrq = 6'h12;
        tick(); tick();
        checkOutput("e2_IntId", {29'd0, IntId}, 32'd1);
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        readCheck("e2_PEND", 2'd1, 32'h10);
        readCheck("e2_STAT", 2'd2, 32'h9);
        checkOutput("e2_svcNoReq", {31'd0, IntReq}, 32'd0);
        Eoi = 1'b1; tick(); Eoi = 1'b0;
        checkOutput("e2_idle", {31'd0, IntReq}, 32'd0);
        tick();
        checkOutput("e2_IntReq4", {31'd0, IntReq}, 32'd1);
        checkOutput("e2_IntId4", {29'd0, IntId}, 32'd4);
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        Eoi = 1'b1; tick(); Eoi = 1'b0;
        DevIrq = 6'h00; tick();

        // Masking a request in flight drops it but keeps it pending.
        DevIrq = 6'h08;
        tick(); tick();
        checkOutput("e3_IntId", {29'd0, IntId}, 32'd3);
        writeReg(2'd0, 32'h00);
        tick();
        checkOutput("e3_drop", {31'd0, IntReq}, 32'd0);
        readCheck("e3_PEND", 2'd1, 32'h08);
        writeReg(2'd1, 32'h08);
        readCheck("e3_PENDclr", 2'd1, 32'h00);
        writeReg(2'd0, 32'h3F);
        DevIrq = 6'h00; tick();

        // W1C colliding with a rising edge leaves the bit set.
        DevIrq = 6'h01; WE = 1'b1; Addr = 2'd1; WD = 32'h1;
        tick();
        WE = 1'b0; WD = 32'd0;
        readCheck("e4_PEND", 2'd1, 32'h01);
        tick();
        IntAck = 1'b1; tick(); IntAck = 1'b0;
        readCheck("e4_STAT", 2'd2, 32'h8);

        // Reset in service clears everything without a clock edge.
        reset = 1'b1;
        #1;
        checkOutput("e5_IntReq", {31'd0, IntReq}, 32'd0);
        checkOutput("e5_IntId", {29'd0, IntId}, 32'd0);
        readCheck("e5_STAT", 2'd2, 32'h0);
        readCheck("e5_MASK", 2'd0, 32'h0);
        DevIrq = 6'h00;
        tick();
        reset = 1'b0;
`endif

        writeReg(2'd0, 32'h3F);
        writeReg(2'd3, 32'h1);
        repeat (3000) applyStimulus();
        IntAck = 1'b0; Eoi = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
